output_switch_sync: RTL

Parametrised, registered successor to the CPU A/B output switch. It routes one of two WIDTH-bit output buses (CPU A or CPU B) to the output pins under control of `ctr_io`, and adds the following:
- a two-flop synchroniser on `ctr_io`;
- a guard interval during every changeover, in which the pins hold a programmable safe value, so that no pin ever shows a mix of A and B data;
- status outputs and a changeover counter.

The block sits between the two CPU cores and the board output pads.

---
 rtl/output_switch_sync.sv | 122 ++++++++++++
 1 files changed

// File: rtl/output_switch_sync.sv
// output_switch_sync: registered A/B output switch.
// It has a two-flop synchroniser on the select input. On every changeover the
// pins are held at SAFE_VALUE for a guard interval before the new source is
// driven. A saturating counter records the completed changeovers.
module output_switch_sync #(
   parameter int               WIDTH        = 8,
   parameter logic [WIDTH-1:0] SAFE_VALUE   = {WIDTH{1'b1}},
   parameter int               GUARD_CYCLES = 4,
   parameter int               CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ctr_io,
   input  logic [WIDTH-1:0] output_from_A,
   input  logic [WIDTH-1:0] output_from_B,
   output logic [WIDTH-1:0] output_pin,
   output logic             active_sel,
   output logic             switching,
   output logic [CNT_W-1:0] switch_count
);

   // Guard down-counter width; at least one bit even for a one-cycle guard.
   localparam int            GW    = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
   localparam logic [GW-1:0] GLOAD = GW'(GUARD_CYCLES - 1);

   localparam logic [1:0] SEL_A = 2'd0;
   localparam logic [1:0] SEL_B = 2'd1;
   localparam logic [1:0] GUARD = 2'd2;

   logic             s1_q, s2_q;
   logic [1:0]       state_q, state_d;
   logic [GW-1:0]    gcnt_q, gcnt_d;
   logic [WIDTH-1:0] pin_q, pin_d;
   logic             act_q, act_d;
   logic             sw_q, sw_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Two-flop synchroniser bringing the asynchronous select into the clk domain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
      end else begin
         s1_q <= ctr_io;
         s2_q <= s1_q;
      end
   end

   // Next-state logic: select states forward data; GUARD holds the safe value
   // and, on its final cycle, commits to whatever the synchronised select says.
   always_comb begin
      state_d = state_q;
      gcnt_d  = gcnt_q;
      pin_d   = pin_q;
      act_d   = act_q;
      sw_d    = sw_q;
      cnt_d   = cnt_q;
      case (state_q)
         SEL_A: begin
            if (!s2_q) begin
               pin_d = output_from_A;
            end else begin
               state_d = GUARD;
               gcnt_d  = GLOAD;
               pin_d   = SAFE_VALUE;
               sw_d    = 1'b1;
            end
         end
         SEL_B: begin
            if (s2_q) begin
               pin_d = output_from_B;
            end else begin
               state_d = GUARD;
               gcnt_d  = GLOAD;
               pin_d   = SAFE_VALUE;
               sw_d    = 1'b1;
            end
         end
         default: begin
            if (gcnt_q != '0) begin
               gcnt_d = gcnt_q - 1'b1;
               pin_d  = SAFE_VALUE;
            end else begin
               // A reversal during the guard is resolved here. Returning to the
               // original source is not counted as a changeover.
               state_d = s2_q ? SEL_B : SEL_A;
               pin_d   = s2_q ? output_from_B : output_from_A;
               sw_d    = 1'b0;
               act_d   = s2_q;
               if ((s2_q != act_q) && (cnt_q != '1)) begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
      endcase
   end

   // State registers; reset parks the block in a full-length guard.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= GUARD;
         gcnt_q  <= GLOAD;
         pin_q   <= SAFE_VALUE;
         act_q   <= 1'b0;
         sw_q    <= 1'b1;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         gcnt_q  <= gcnt_d;
         pin_q   <= pin_d;
         act_q   <= act_d;
         sw_q    <= sw_d;
         cnt_q   <= cnt_d;
      end
   end

   assign output_pin   = pin_q;
   assign active_sel   = act_q;
   assign switching    = sw_q;
   assign switch_count = cnt_q;

endmodule
